instruction_fetcher: RTL and testbench

Fetch stage sitting directly downstream of the instruction cache: holds the PC, issues one request at a time to the cache, and advances the PC by 2 or 4 depending on the cache's compressed flag. It buffers fetched instructions, with their PC and predicted next PC, in a small FIFO. The decoder drains the FIFO through a valid/ready handshake. A redirect input from the backend flushes the FIFO and restarts fetch at a new PC.

---
 rtl/instruction_fetcher.sv | 159 +++++++++++++++
 tb/tb_instruction_fetcher.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetcher.sv
// Fetch stage: holds the PC, issues single outstanding i-cache requests and queues fetched instructions.
// Optional JAL target prediction is enabled by defining IFETCH_JAL_PREDICT_EN.
module instruction_fetcher #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] icache_addr,
  output logic        icache_req,
  input  logic [31:0] icache_data,
  input  logic        icache_ready,
  input  logic        icache_compressed,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pred_pc,
  output logic        inst_compressed
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] pred;
    logic        comp;
  } entry_t;

  state_t           state;
  logic [31:0]      pc;
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             full_c;
  logic             pop_c;
  logic             push_c;
  logic [CNT_W-1:0] cnt_after_c;
  logic [31:0]      pred_c;
  logic [31:0]      flush_target_c;
  entry_t           head_c;

  assign full_c         = (count == CNT_W'(DEPTH));
  assign pop_c          = inst_valid && inst_ready;
  assign push_c         = (state == WAIT) && icache_ready;
  assign cnt_after_c    = count + CNT_W'(1) - CNT_W'(pop_c);
  assign flush_target_c = flush_pc & 32'hFFFF_FFFE;

  // Queue head is presented straight from storage.
  assign head_c          = mem[rd_ptr];
  assign inst_valid      = (count != '0);
  assign inst_data       = head_c.data;
  assign inst_pc         = head_c.pc;
  assign inst_pred_pc    = head_c.pred;
  assign inst_compressed = head_c.comp;

  // Next-PC prediction for the response currently on the cache bus.
  always_comb begin
    pred_c = pc + (icache_compressed ? 32'd2 : 32'd4);
`ifdef IFETCH_JAL_PREDICT_EN
    if (!icache_compressed && (icache_data[6:0] == 7'b1101111)) begin
      pred_c = pc + {{11{icache_data[31]}}, icache_data[31], icache_data[19:12],
                     icache_data[20], icache_data[30:21], 1'b0};
    end
`endif
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      icache_req  <= 1'b0;
      icache_addr <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        // Redirect: empty the queue, retarget the PC, retire any in-flight request unused.
        pc     <= flush_target_c;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        case (state)
          WAIT: begin
            if (icache_ready) begin
              state      <= IDLE;
              icache_req <= 1'b0;
            end else begin
              state <= DROP;
            end
          end
          DROP: begin
            if (icache_ready) begin
              state      <= IDLE;
              icache_req <= 1'b0;
            end
          end
          default: ;
        endcase
      end else begin
        if (pop_c) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
        case (state)
          IDLE: begin
            if (!full_c || pop_c) begin
              state       <= WAIT;
              icache_req  <= 1'b1;
              icache_addr <= pc;
            end
          end
          WAIT: begin
            if (icache_ready) begin
              mem[wr_ptr] <= '{data: icache_data, pc: pc, pred: pred_c, comp: icache_compressed};
              wr_ptr      <= wr_ptr + PTR_W'(1);
              pc          <= pred_c;
              // Keep fetching back-to-back while the queue has room after this push.
              if (cnt_after_c < CNT_W'(DEPTH)) begin
                icache_addr <= pred_c;
              end else begin
                state      <= IDLE;
                icache_req <= 1'b0;
              end
            end
          end
          DROP: begin
            if (icache_ready) begin
              state      <= IDLE;
              icache_req <= 1'b0;
            end
          end
          default: begin
            state      <= IDLE;
            icache_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: sequential fetch, compressed mix, full queue, flush, freeze, async reset, JAL.
module tb_instruction_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] icache_addr;
  logic        icache_req;
  logic [31:0] icache_data;
  logic        icache_ready;
  logic        icache_compressed;
  logic        flush_in;
  logic [31:0] flush_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pred_pc;
  logic        inst_compressed;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetcher #(.DEPTH(8), .RESET_PC(32'h0000_0000)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .icache_addr       (icache_addr),
    .icache_req        (icache_req),
    .icache_data       (icache_data),
    .icache_ready      (icache_ready),
    .icache_compressed (icache_compressed),
    .flush_in          (flush_in),
    .flush_pc          (flush_pc),
    .inst_valid        (inst_valid),
    .inst_ready        (inst_ready),
    .inst_data         (inst_data),
    .inst_pc           (inst_pc),
    .inst_pred_pc      (inst_pred_pc),
    .inst_compressed   (inst_compressed)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  // One-cycle cache response.
  task automatic drive_resp(input logic [31:0] d, input logic c);
    icache_ready      = 1'b1;
    icache_data       = d;
    icache_compressed = c;
    tick();
    icache_ready      = 1'b0;
  endtask

  logic [31:0] exp_pc   [3];
  logic [31:0] exp_pred [3];
  logic        exp_comp [3];
  logic [31:0] jal_exp;

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; icache_data = '0; icache_ready = 1'b0;
    icache_compressed = 1'b0; flush_in = 1'b0; flush_pc = '0; inst_ready = 1'b0;
    #2 rst_in = 1'b0;
    repeat (3) tick();
    check("rst_req",   icache_req,      32'd0);
    check("rst_addr",  icache_addr,     32'h0);
    check("rst_valid", inst_valid,      32'd0);
    check("rst_data",  inst_data,       32'h0);
    check("rst_pc",    inst_pc,         32'h0);
    check("rst_pred",  inst_pred_pc,    32'h0);
    check("rst_comp",  inst_compressed, 32'd0);
    rst_in = 1'b1;
    tick();
    check("first_req",  icache_req,  32'd1);
    check("first_addr", icache_addr, 32'h0);

    // Sequential 32-bit fetch, response every second cycle.
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", icache_addr, 32'(4 * i));
      drive_resp(32'h0000_0013 + (32'(i) << 7), 1'b0);
      check("seq_valid", inst_valid, 32'd1);
      check("seq_req",   icache_req, 32'd1);
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      check("seq_pc",   inst_pc,         32'(4 * j));
      check("seq_pred", inst_pred_pc,    32'(4 * j + 4));
      check("seq_data", inst_data,       32'h0000_0013 + (32'(j) << 7));
      check("seq_comp", inst_compressed, 32'd0);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
    end
    check("seq_empty", inst_valid, 32'd0);

    // Redirect to 0x100 while a request is pending, then a compressed/32-bit mix.
    flush_in = 1'b1; flush_pc = 32'h0000_0100;
    tick();
    flush_in = 1'b0;
    check("drop_req",  icache_req,  32'd1);
    check("drop_addr", icache_addr, 32'h10);
    drive_resp(32'hFFFF_FFFF, 1'b0);
    check("drop_idle",  icache_req, 32'd0);
    check("drop_valid", inst_valid, 32'd0);
    tick();
    check("mix_addr0", icache_addr, 32'h100);
    drive_resp(32'h0000_4501, 1'b1);
    check("mix_addr1", icache_addr, 32'h102);
    drive_resp(32'h0000_0013, 1'b0);
    check("mix_addr2", icache_addr, 32'h106);
    drive_resp(32'h0000_0013, 1'b0);
    check("mix_addr3", icache_addr, 32'h10A);
    exp_pc   = '{32'h100, 32'h102, 32'h106};
    exp_pred = '{32'h102, 32'h106, 32'h10A};
    exp_comp = '{1'b1, 1'b0, 1'b0};
    for (int j = 0; j < 3; j++) begin
      check("mix_pc",   inst_pc,         exp_pc[j]);
      check("mix_pred", inst_pred_pc,    exp_pred[j]);
      check("mix_comp", inst_compressed, 32'(exp_comp[j]));
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
    end
    check("mix_empty", inst_valid, 32'd0);

    // Always-ready cache with a stalled decoder fills the queue.
    icache_ready = 1'b1; icache_data = 32'h0000_0013; icache_compressed = 1'b0;
    repeat (7) tick();
    check("fill7_req", icache_req, 32'd1);
    tick();
    icache_ready = 1'b0;
    check("full_req",   icache_req, 32'd0);
    check("full_valid", inst_valid, 32'd1);
    check("full_head",  inst_pc,    32'h10A);
    tick();
    check("full_hold", icache_req, 32'd0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("restart_req",  icache_req,  32'd1);
    check("restart_addr", icache_addr, 32'h12A);
    check("restart_head", inst_pc,     32'h10E);

    // Flush to an odd address mid-request; response arrives three cycles later.
    flush_in = 1'b1; flush_pc = 32'h0000_2001;
    tick();
    flush_in = 1'b0;
    check("fl_valid", inst_valid,  32'd0);
    check("fl_req",   icache_req,  32'd1);
    check("fl_addr",  icache_addr, 32'h12A);
    repeat (2) tick();
    check("fl_valid2", inst_valid, 32'd0);
    drive_resp(32'hDEAD_0013, 1'b0);
    check("fl_disc_req",   icache_req, 32'd0);
    check("fl_disc_valid", inst_valid, 32'd0);
    tick();
    check("fl_new_req",  icache_req,  32'd1);
    check("fl_new_addr", icache_addr, 32'h2000);
    check("fl_new_valid", inst_valid, 32'd0);
    drive_resp(32'h1234_5013, 1'b0);
    check("fl_resp_valid", inst_valid,  32'd1);
    check("fl_resp_pc",    inst_pc,     32'h2000);
    check("fl_resp_data",  inst_data,   32'h1234_5013);
    check("fl_next_addr",  icache_addr, 32'h2004);

    // Freeze: response and pop are both ignored.
    rdy_in = 1'b0; icache_ready = 1'b1; icache_data = 32'h5555_0013; inst_ready = 1'b1;
    tick();
    check("frz_addr",  icache_addr, 32'h2004);
    check("frz_req",   icache_req,  32'd1);
    check("frz_valid", inst_valid,  32'd1);
    check("frz_pc",    inst_pc,     32'h2000);
    rdy_in = 1'b1; icache_ready = 1'b0; inst_ready = 1'b0;

    // Asynchronous reset between clock edges while a request is outstanding.
    #2 rst_in = 1'b0;
    #1;
    check("arst_req",   icache_req,   32'd0);
    check("arst_addr",  icache_addr,  32'h0);
    check("arst_valid", inst_valid,   32'd0);
    check("arst_data",  inst_data,    32'h0);
    check("arst_pc",    inst_pc,      32'h0);
    check("arst_pred",  inst_pred_pc, 32'h0);
    tick();
    rst_in = 1'b1;
    tick();
    check("arst_restart", icache_req, 32'd1);

    // JAL +0x40 at 0x10.
    flush_in = 1'b1; flush_pc = 32'h0000_0010;
    tick();
    flush_in = 1'b0;
    drive_resp(32'h0000_0000, 1'b0);
    tick();
    check("jal_addr0", icache_addr, 32'h10);
    drive_resp(32'h0400_006F, 1'b0);
`ifdef IFETCH_JAL_PREDICT_EN
    jal_exp = 32'h50;
`else
    jal_exp = 32'h14;
`endif
    check("jal_pc",   inst_pc,      32'h10);
    check("jal_pred", inst_pred_pc, jal_exp);
    check("jal_addr", icache_addr,  jal_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
